// File: rtl/note_phase_accumulator.sv
// note_phase_accumulator
// ----------------------
// Single-voice DDS phase accumulator. A 24-bit frequency step from the
// note-to-step lookup is accepted through a one-entry holding register and
// applied at sample-tick boundaries. The phase advances by the applied step
// on every sample tick. Note gating supports start, legato retune and a
// click-free release that parks the phase at zero on the next wrap. An
// optional exponential glide moves the applied step toward its target.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   sample_tick  one-cycle strobe at the sample rate
//   step_in      new frequency step (STEP_W)
//   step_valid   step_in valid
//   step_ready   holding register free (combinational, !pending)
//   note_on      one-cycle gate-on strobe
//   note_off     one-cycle gate-off strobe
//   phase        current phase, registered (PHASE_W)
//   phase_valid  one-cycle pulse, phase was updated by a tick
//   wrap         one-cycle pulse, accumulator carried out
//   active       voice state is not IDLE
//   cur_step     step currently applied to the accumulator (STEP_W)
//
// Step handshake: a step is transferred in any cycle where step_valid and
// step_ready are both high (never while rst is high). The producer must
// hold step_in stable while step_valid is high until that transfer. A
// transferred step waits in the holding register (step_ready low) until
// the next sample tick moves it to the glide target, or until a note start
// from IDLE applies it directly.

module note_phase_accumulator #(
  parameter int PHASE_W     = 24,
  parameter int STEP_W      = 24,
  parameter int GLIDE_SHIFT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_tick,
  input  logic [STEP_W-1:0] step_in,
  input  logic              step_valid,
  output logic              step_ready,
  input  logic              note_on,
  input  logic              note_off,
  output logic [PHASE_W-1:0] phase,
  output logic              phase_valid,
  output logic              wrap,
  output logic              active,
  output logic [STEP_W-1:0] cur_step
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [STEP_W-1:0]   target;
  logic [STEP_W-1:0]   hold;
  logic                pending;

  logic                xfer;
  logic [PHASE_W:0]    sum;
  logic                carry;
  logic                release_done;
  logic signed [STEP_W:0] diff;
  logic signed [STEP_W:0] delta;
  logic [STEP_W-1:0]   glide_step;

  assign step_ready = !pending;
  assign xfer       = step_valid && !pending;

  // One extra bit captures the carry out of the phase addition.
  assign sum   = {1'b0, phase} + {1'b0, cur_step};
  assign carry = sum[PHASE_W];

  // Signed distance to target, scaled down for the exponential glide.
  // The arithmetic shift floors toward minus infinity, so a small negative
  // distance still yields -1 and the step lands exactly on target.
  assign diff  = $signed({1'b0, target}) - $signed({1'b0, cur_step});
  assign delta = diff >>> GLIDE_SHIFT;

  always_comb begin
    glide_step = target;
    if (GLIDE_SHIFT != 0 && delta != '0) begin
      glide_step = cur_step + delta[STEP_W-1:0];
    end
  end

  // A release ends on the tick that carries out, unless a new note_on in
  // the same cycle takes priority and keeps the voice sounding.
  assign release_done = (state == S_RELEASE) && sample_tick && carry && !note_on;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (note_on) state_nx = S_RUN;
      S_RUN:     if (!note_on && note_off) state_nx = S_RELEASE;
      S_RELEASE: begin
        if (note_on)           state_nx = S_RUN;
        else if (release_done) state_nx = S_IDLE;
      end
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      phase       <= '0;
      cur_step    <= '0;
      target      <= '0;
      hold        <= '0;
      pending     <= 1'b0;
      phase_valid <= 1'b0;
      wrap        <= 1'b0;
      active      <= 1'b0;
    end else begin
      state       <= state_nx;
      active      <= (state_nx != S_IDLE);
      phase_valid <= sample_tick;
      wrap        <= 1'b0;

      case (state)
        S_IDLE: begin
          phase <= '0;
          if (note_on) begin
            // Note start applies the newest step at once, without glide.
            if (pending) begin
              cur_step <= hold;
              target   <= hold;
              pending  <= 1'b0;
            end else begin
              cur_step <= target;
            end
          end else if (sample_tick && pending) begin
            target  <= hold;
            pending <= 1'b0;
          end
        end

        S_RUN, S_RELEASE: begin
          if (sample_tick) begin
            if (pending) begin
              target  <= hold;
              pending <= 1'b0;
            end
            // Glide is computed from the pre-tick target, so a freshly
            // applied target starts moving cur_step on the next tick.
            cur_step <= glide_step;
            if (release_done) begin
              phase <= '0;
              wrap  <= 1'b1;
            end else begin
              phase <= sum[PHASE_W-1:0];
              wrap  <= carry;
            end
          end
        end

        default: phase <= '0;
      endcase

      // A transfer only happens with pending low, so it never collides
      // with the consumption paths above.
      if (xfer) begin
        hold    <= step_in;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_note_phase_accumulator.sv
// Bench for note_phase_accumulator. Two instances share one stimulus:
// inst 0 uses the default glide (GLIDE_SHIFT=4), inst 1 uses instant step
// changes (GLIDE_SHIFT=0). Every cycle both are compared with a
// behavioural model; directed steps add explicit expected values.

module tb_note_phase_accumulator;

  localparam int W = 24;
  localparam int FULL = 1 << W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample_tick = 1'b0;
  logic [W-1:0]  step_in = '0;
  logic          step_valid = 1'b0;
  logic          note_on = 1'b0;
  logic          note_off = 1'b0;

  logic          step_ready0, phase_valid0, wrap0, active0;
  logic [W-1:0]  phase0, cur_step0;
  logic          step_ready1, phase_valid1, wrap1, active1;
  logic [W-1:0]  phase1, cur_step1;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  note_phase_accumulator #(.PHASE_W(24), .STEP_W(24), .GLIDE_SHIFT(4)) dut0 (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .step_in(step_in),
    .step_valid(step_valid), .step_ready(step_ready0), .note_on(note_on),
    .note_off(note_off), .phase(phase0), .phase_valid(phase_valid0),
    .wrap(wrap0), .active(active0), .cur_step(cur_step0)
  );

  note_phase_accumulator #(.PHASE_W(24), .STEP_W(24), .GLIDE_SHIFT(0)) dut1 (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .step_in(step_in),
    .step_valid(step_valid), .step_ready(step_ready1), .note_on(note_on),
    .note_off(note_off), .phase(phase1), .phase_valid(phase_valid1),
    .wrap(wrap1), .active(active1), .cur_step(cur_step1)
  );

  // ---------------- reference model ----------------
  // Voice mode: 0 silent, 1 sounding, 2 releasing.
  int  gshift [2] = '{4, 0};
  int  m_mode [2];
  int  m_phase[2];
  int  m_cur  [2];
  int  m_tgt  [2];
  int  m_hold [2];
  bit  m_pend [2];
  bit  m_pv   [2];
  bit  m_wrap [2];
  bit  last_xfer;

  // Floor division of a signed distance by 2^g.
  function automatic int floor_div(input int d, input int g);
    int den;
    den = 1 << g;
    if (d >= 0) return d / den;
    return -((-d + den - 1) / den);
  endfunction

  task automatic model_clk(input int i);
    int  old_tgt, s, q, old_mode;
    bit  xf, carry;
    if (rst) begin
      m_mode[i] = 0; m_phase[i] = 0; m_cur[i] = 0; m_tgt[i] = 0;
      m_hold[i] = 0; m_pend[i] = 0; m_pv[i] = 0; m_wrap[i] = 0;
      return;
    end
    xf       = step_valid && !m_pend[i];
    old_mode = m_mode[i];
    m_pv[i]   = sample_tick;
    m_wrap[i] = 0;
    if (old_mode == 0) begin
      m_phase[i] = 0;
      if (note_on) begin
        m_mode[i] = 1;
        if (m_pend[i]) begin
          m_tgt[i] = m_hold[i]; m_pend[i] = 0;
        end
        m_cur[i] = m_tgt[i];
      end else if (sample_tick && m_pend[i]) begin
        m_tgt[i] = m_hold[i]; m_pend[i] = 0;
      end
    end else begin
      if (sample_tick) begin
        s       = m_phase[i] + m_cur[i];
        carry   = (s >= FULL);
        old_tgt = m_tgt[i];
        if (m_pend[i]) begin
          m_tgt[i] = m_hold[i]; m_pend[i] = 0;
        end
        if (gshift[i] == 0) m_cur[i] = old_tgt;
        else begin
          q = floor_div(old_tgt - m_cur[i], gshift[i]);
          m_cur[i] = (q == 0) ? old_tgt : m_cur[i] + q;
        end
        m_wrap[i] = carry;
        if (old_mode == 2 && carry && !note_on) begin
          m_phase[i] = 0;
          m_mode[i]  = 0;
        end else begin
          m_phase[i] = s % FULL;
        end
      end
      if (note_on) m_mode[i] = 1;
      else if (note_off && old_mode == 1) m_mode[i] = 2;
    end
    if (xf) begin
      m_hold[i] = step_in; m_pend[i] = 1;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("m0_phase",  {8'h0, phase0},    m_phase[0]);
    chk("m0_cur",    {8'h0, cur_step0}, m_cur[0]);
    chk("m0_pv",     {31'h0, phase_valid0}, {31'h0, m_pv[0]});
    chk("m0_wrap",   {31'h0, wrap0},    {31'h0, m_wrap[0]});
    chk("m0_active", {31'h0, active0},  {31'h0, m_mode[0] != 0});
    chk("m0_ready",  {31'h0, step_ready0}, {31'h0, !m_pend[0]});
    chk("m1_phase",  {8'h0, phase1},    m_phase[1]);
    chk("m1_cur",    {8'h0, cur_step1}, m_cur[1]);
    chk("m1_pv",     {31'h0, phase_valid1}, {31'h0, m_pv[1]});
    chk("m1_wrap",   {31'h0, wrap1},    {31'h0, m_wrap[1]});
    chk("m1_active", {31'h0, active1},  {31'h0, m_mode[1] != 0});
    chk("m1_ready",  {31'h0, step_ready1}, {31'h0, !m_pend[1]});
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic cycle();
    @(posedge clk);
    last_xfer = !rst && step_valid && !m_pend[0];
    model_clk(0);
    model_clk(1);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst = 1'b1; cycle(); rst = 1'b0;
  endtask

  task automatic send_step(input logic [W-1:0] v);
    step_valid = 1'b1; step_in = v; cycle(); step_valid = 1'b0;
  endtask

  task automatic tick();
    sample_tick = 1'b1; cycle(); sample_tick = 1'b0;
  endtask

  task automatic gate(input bit on, input bit off);
    note_on = on; note_off = off; cycle(); note_on = 1'b0; note_off = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [W-1:0] prev;

    // Reset state
    cycle();
    do_reset();
    chk("rst_phase",  {8'h0, phase0}, 32'h0);
    chk("rst_cur",    {8'h0, cur_step0}, 32'h0);
    chk("rst_active", {31'h0, active0}, 32'h0);
    chk("rst_ready",  {31'h0, step_ready0}, 32'h1);
    chk("rst_pv",     {31'h0, phase_valid0}, 32'h0);
    chk("rst_wrap",   {31'h0, wrap0}, 32'h0);

    // 1. Basic accumulation
    send_step(24'h001000);
    gate(1, 0);
    chk("t1_cur", {8'h0, cur_step0}, 32'h1000);
    for (int k = 1; k <= 4096; k++) begin
      tick();
      chk("t1_phase", {8'h0, phase0}, (k * 32'h1000) & 32'hFFFFFF);
      chk("t1_wrap",  {31'h0, wrap0}, (k == 4096) ? 32'h1 : 32'h0);
    end

    // 2. Glide on inst 0
    do_reset();
    send_step(24'h010000);
    gate(1, 0);
    send_step(24'h020000);
    tick();
    chk("t2_n",  {8'h0, cur_step0}, 32'h010000);
    tick();
    chk("t2_n1", {8'h0, cur_step0}, 32'h011000);
    tick();
    chk("t2_n2", {8'h0, cur_step0}, 32'h011F00);
    prev = cur_step0;
    for (int k = 0; k < 400 && cur_step0 != 24'h020000; k++) begin
      tick();
      chk("t2_no_overshoot", {31'h0, cur_step0 <= 24'h020000}, 32'h1);
      chk("t2_monotonic",    {31'h0, cur_step0 > prev}, 32'h1);
      prev = cur_step0;
    end
    chk("t2_final", {8'h0, cur_step0}, 32'h020000);

    // 3. Release on inst 1 (instant step changes)
    do_reset();
    send_step(24'h100000);
    gate(1, 0);
    tick();
    send_step(24'h200000);
    repeat (4) tick();
    chk("t3_pre_phase", {8'h0, phase1}, 32'h700000);
    chk("t3_pre_cur",   {8'h0, cur_step1}, 32'h200000);
    gate(0, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t3_rel_phase",  {8'h0, phase1}, 32'h900000 + k * 32'h200000);
      chk("t3_rel_active", {31'h0, active1}, 32'h1);
      chk("t3_rel_wrap",   {31'h0, wrap1}, 32'h0);
    end
    tick();
    chk("t3_end_phase",  {8'h0, phase1}, 32'h0);
    chk("t3_end_wrap",   {31'h0, wrap1}, 32'h1);
    chk("t3_end_active", {31'h0, active1}, 32'h0);
    tick();
    chk("t3_idle_pv",    {31'h0, phase_valid1}, 32'h1);
    chk("t3_idle_phase", {8'h0, phase1}, 32'h0);

    // 4. Backpressure
    do_reset();
    step_valid = 1'b1; step_in = 24'h000100;
    cycle();
    chk("t4_ready_after_first", {31'h0, step_ready0}, 32'h0);
    step_in = 24'h000200;
    repeat (3) begin
      cycle();
      chk("t4_held_off", {31'h0, step_ready0}, 32'h0);
    end
    sample_tick = 1'b1; cycle(); sample_tick = 1'b0;
    chk("t4_ready_after_tick", {31'h0, step_ready0}, 32'h1);
    cycle();
    chk("t4_second_xfer", {31'h0, step_ready0}, 32'h0);
    step_valid = 1'b0;
    tick();
    gate(1, 0);
    chk("t4_target", {8'h0, cur_step0}, 32'h000200);

    // 5. Gate priority
    do_reset();
    send_step(24'h300000);
    gate(1, 0);
    gate(1, 1);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("t5_run_phase", {8'h0, phase1}, (k * 32'h300000) & 32'hFFFFFF);
    end
    chk("t5_run_wrap",   {31'h0, wrap1}, 32'h1);
    chk("t5_run_active", {31'h0, active1}, 32'h1);
    gate(0, 1);
    tick();
    chk("t5_rel_phase", {8'h0, phase1}, 32'h500000);
    gate(1, 0);
    chk("t5_retrig_phase",  {8'h0, phase1}, 32'h500000);
    chk("t5_retrig_active", {31'h0, active1}, 32'h1);
    repeat (4) tick();
    chk("t5_legato_phase",  {8'h0, phase1}, 32'h100000);
    chk("t5_legato_active", {31'h0, active1}, 32'h1);

    // 6. Reset mid-note with a pending step
    do_reset();
    send_step(24'h001000);
    gate(1, 0);
    tick();
    send_step(24'h002000);
    chk("t6_pending", {31'h0, step_ready0}, 32'h0);
    do_reset();
    chk("t6_phase",  {8'h0, phase0}, 32'h0);
    chk("t6_active", {31'h0, active0}, 32'h0);
    chk("t6_ready",  {31'h0, step_ready0}, 32'h1);
    chk("t6_cur",    {8'h0, cur_step0}, 32'h0);
    tick();
    chk("t6_tick_pv",    {31'h0, phase_valid0}, 32'h1);
    chk("t6_tick_phase", {8'h0, phase0}, 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 299) == 0);
      sample_tick = ($urandom_range(0, 3) == 0);
      note_on     = ($urandom_range(0, 39) == 0);
      note_off    = ($urandom_range(0, 29) == 0);
      if (!(step_valid && !last_xfer)) begin
        step_valid = ($urandom_range(0, 9) == 0);
        step_in    = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 24'h00FFFF))
                                                 : W'($urandom);
      end
      cycle();
    end
    rst = 1'b0; sample_tick = 1'b0; note_on = 1'b0; note_off = 1'b0; step_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
